// File: rtl/axil_gpio.sv
// AXI4-Lite GPIO block: up to 64 bidirectional pins with per-pin direction,
// output registers, and a 2-flop input synchronizer feeding the DATA reads.
module axil_gpio #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int N_GPIO     = 64
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]              s_axil_awprot,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,

    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]              s_axil_arprot,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,

    inout  wire  [N_GPIO-1:0]       gpio
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    // Bits at or above N_GPIO are never written, so they stay zero and read back as zero.
    localparam logic [63:0] VALID_MASK = (N_GPIO >= 64) ? {64{1'b1}} : ((64'd1 << N_GPIO) - 64'd1);

    logic [63:0]           out_reg;
    logic [63:0]           dir_reg;
    logic [N_GPIO-1:0]     sync_meta;
    logic [N_GPIO-1:0]     sync_pins;
    logic [63:0]           pin_state;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic [63:0]           wr_bits;
    logic [63:0]           wr_val;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  wr_fire;
    logic                  rd_fire;

    assign s_axil_bresp = 2'b00;
    assign s_axil_rresp = 2'b00;
    assign pin_state    = 64'(sync_pins);
    assign wr_fire      = s_axil_awready && s_axil_awvalid && s_axil_wvalid;
    assign rd_fire      = s_axil_arready && s_axil_arvalid;

    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            wr_mask[8*i +: 8] = {8{s_axil_wstrb[i]}};
        end
        wr_bits = s_axil_awaddr[2] ? {wr_mask, 32'h0} : {32'h0, wr_mask};
        wr_val  = {s_axil_wdata, s_axil_wdata} & VALID_MASK;
    end

    always_comb begin
        case (s_axil_araddr[3:2])
            2'd0:    rd_word = pin_state[31:0];
            2'd1:    rd_word = pin_state[63:32];
            2'd2:    rd_word = dir_reg[31:0];
            default: rd_word = dir_reg[63:32];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= '0;
            sync_pins <= '0;
        end else begin
            sync_meta <= gpio;
            sync_pins <= sync_meta;
        end
    end

    // Ready is raised for one cycle; the register update and bvalid happen at the accepting edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            out_reg        <= '0;
            dir_reg        <= '0;
        end else begin
            if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
            if (wr_fire) begin
                s_axil_awready <= 1'b0;
                s_axil_wready  <= 1'b0;
                s_axil_bvalid  <= 1'b1;
                if (s_axil_awaddr[3]) begin
                    dir_reg <= (dir_reg & ~wr_bits) | (wr_val & wr_bits);
                end else begin
                    out_reg <= (out_reg & ~wr_bits) | (wr_val & wr_bits);
                end
            end else if (s_axil_awvalid && s_axil_wvalid && !s_axil_bvalid && !s_axil_awready) begin
                s_axil_awready <= 1'b1;
                s_axil_wready  <= 1'b1;
            end else begin
                s_axil_awready <= 1'b0;
                s_axil_wready  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= '0;
        end else begin
            if (s_axil_rvalid && s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
            if (rd_fire) begin
                s_axil_arready <= 1'b0;
                s_axil_rvalid  <= 1'b1;
                s_axil_rdata   <= rd_word;
            end else if (s_axil_arvalid && !s_axil_rvalid && !s_axil_arready) begin
                s_axil_arready <= 1'b1;
            end else begin
                s_axil_arready <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < N_GPIO; i++) begin : g_pin
        assign gpio[i] = dir_reg[i] ? out_reg[i] : 1'bz;
    end

    // Protection bits, untouched address bits and unimplemented OUT bits have no effect.
    logic unused_bits;
    assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr, out_reg};

endmodule

// File: tb/tb_axil_gpio.sv
// Randomized self-checking bench for axil_gpio, compared against a register/pin
// reference model kept as four 32-bit words plus the externally driven pin values.
module tb_axil_gpio;

    localparam int N_GPIO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    wire  [N_GPIO-1:0] gpio;

    logic [63:0] ext_val;
    logic [31:0] model_reg [4];
    logic [63:0] tb_dir;
    int          tests_run = 0;
    int          tests_failed = 0;

    axil_gpio #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .N_GPIO(N_GPIO)) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .gpio(gpio)
    );

    always #5 clk = ~clk;

    // The bench drives every pin the model says is an input, so no pin floats.
    assign tb_dir = {model_reg[3], model_reg[2]};
    for (genvar i = 0; i < N_GPIO; i++) begin : g_ext
        assign gpio[i] = tb_dir[i] ? 1'bz : ext_val[i];
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) model_reg[k] = 32'h0;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr[3:2]);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model_reg[idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [63:0] pins;
        logic [63:0] dir;
        logic [63:0] outv;
        dir  = {model_reg[3], model_reg[2]};
        outv = {model_reg[1], model_reg[0]};
        for (int i = 0; i < 64; i++) pins[i] = dir[i] ? outv[i] : ext_val[i];
        case (addr[3:2])
            2'd0:    return pins[31:0];
            2'd1:    return pins[63:32];
            2'd2:    return model_reg[2];
            default: return model_reg[3];
        endcase
    endfunction

    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        model_write(addr, data, strb);
        awaddr = addr; wdata = data; wstrb = strb; awprot = 3'($urandom);
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        checkOutput("awready", awready, 1);
        checkOutput("wready", wready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        checkOutput("bvalid", bvalid, 1);
        checkOutput("bresp", bresp, 0);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        checkOutput("bvalid_clear", bvalid, 0);
    endtask

    task automatic check_read(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        int n;
        logic [31:0] got;
        repeat (3) @(posedge clk);
        #1;
        araddr = addr; arprot = 3'($urandom); arvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
        checkOutput("arready", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        checkOutput("rvalid", rvalid, 1);
        checkOutput("rresp", rresp, 0);
        got = rdata;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        checkOutput("rvalid_clear", rvalid, 0);
        checkOutput(tag, got, expected);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a, d, exp_rd;
        int n;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        ext_val = 64'h0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", {awready, wready, arready}, 0);
        checkOutput("rst_valid", {bvalid, rvalid}, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_resp", {bresp, rresp}, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_read("rst_dir_lo", 32'h08, 32'h0);
        check_read("rst_dir_hi", 32'h0C, 32'h0);

        axil_write(32'h08, 32'hFFFF_FFFF, 4'hF);
        axil_write(32'h00, 32'hAAAA_5555, 4'hF);
        checkOutput("pins_lo_a", gpio[31:0], 32'hAAAA_5555);
        axil_write(32'h00, 32'h5555_AAAA, 4'hF);
        checkOutput("pins_lo_b", gpio[31:0], 32'h5555_AAAA);

        axil_write(32'h08, 32'h0, 4'hF);
        ext_val[31:0] = 32'h1234_5678;
        check_read("in_lo_a", 32'h00, 32'h1234_5678);
        ext_val[31:0] = 32'h8765_4321;
        check_read("in_lo_b", 32'h00, 32'h8765_4321);

        axil_write(32'h0C, 32'h0000_FFFF, 4'hF);
        axil_write(32'h04, 32'hDEAD_CAFE, 4'hF);
        checkOutput("pins_hi_out", gpio[47:32], 16'hCAFE);
        ext_val[63:48] = 16'hBEEF;
        check_read("mixed_hi", 32'h04, 32'hBEEF_CAFE);

        axil_write(32'h08, 32'h0, 4'hF);
        axil_write(32'h08, 32'h1234_5678, 4'b0010);
        check_read("strb_dir", 32'h08, 32'h0000_5600);

        // One-sided valids must never be accepted.
        awvalid = 1'b1;
        repeat (4) begin @(posedge clk); #1; checkOutput("aw_only", {awready, wready, bvalid}, 0); end
        awvalid = 1'b0; wvalid = 1'b1;
        repeat (4) begin @(posedge clk); #1; checkOutput("w_only", {awready, wready, bvalid}, 0); end
        wvalid = 1'b0;

        for (int it = 0; it < 40; it++) begin
            ext_val = {$urandom, $urandom};
            a = {$urandom_range(0, 255) << 4} | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            axil_write(a, $urandom, 4'($urandom));
            checkOutput("rand_pins", gpio & tb_dir, {model_reg[1], model_reg[0]} & tb_dir);
            a = (32'($urandom_range(0, 3)) << 2) | {$urandom_range(0, 15) << 8};
            check_read("rand_read", a, model_read(a));
        end

        // Stall both responses with a second transaction waiting on each channel.
        exp_rd = model_reg[2];
        model_write(32'h0C, 32'h00FF_00FF, 4'hF);
        awaddr = 32'h0C; wdata = 32'h00FF_00FF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h08; arvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(awready && arready) && n < 20);
        checkOutput("hold_accept", {awready, arready}, 2'b11);
        @(posedge clk); #1;
        wdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 5; c++) begin
            checkOutput("hold_valid", {bvalid, rvalid}, 2'b11);
            checkOutput("hold_rdata", rdata, exp_rd);
            checkOutput("hold_noacc", {awready, wready, arready}, 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        model_reset();
        #1;
        checkOutput("abort_valid", {bvalid, rvalid}, 0);
        checkOutput("abort_ready", {awready, wready, arready}, 0);
        checkOutput("abort_rdata", rdata, 0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        ext_val = {$urandom, $urandom};
        check_read("post_dir_lo", 32'h08, 32'h0);
        check_read("post_dir_hi", 32'h0C, 32'h0);
        check_read("post_pins_lo", 32'h00, ext_val[31:0]);
        check_read("post_pins_hi", 32'h04, ext_val[63:32]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
